mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: shares one downstream memory port among NUM_PORTS requesters    |
// | using fixed-priority or round-robin arbitration with registered outputs.     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 1,
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int IDX_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_read_i,
  input  logic [NUM_PORTS-1:0]             req_write_i,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]    req_byte_enable_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata_i,
  output logic [NUM_PORTS-1:0]             req_resp_o,
  output logic [DATA_WIDTH-1:0]            req_rdata_o,
  output logic [IDX_WIDTH-1:0]             grant_idx_o,
  output logic                             mem_read_o,
  output logic                             mem_write_o,
  output logic [BE_WIDTH-1:0]              mem_byte_enable_o,
  output logic [ADDR_WIDTH-1:0]            mem_address_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic                             mem_resp_i,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [IDX_WIDTH-1:0]    grant_q;
  logic [IDX_WIDTH-1:0]    rr_ptr_q;
  logic [IDX_WIDTH-1:0]    rr_ptr_d;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [BE_WIDTH-1:0]     mem_be_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [NUM_PORTS-1:0]    req_resp_q;

  logic [NUM_PORTS-1:0]    pending;
  logic                    any_pending;
  logic [IDX_WIDTH-1:0]    win_idx;
  logic [NUM_PORTS-1:0]    resp_onehot;

  logic [ADDR_WIDTH-1:0]   port_addr  [NUM_PORTS];
  logic [BE_WIDTH-1:0]     port_be    [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   port_wdata [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign port_addr[gi]  = req_address_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_be[gi]    = req_byte_enable_i[gi*BE_WIDTH +: BE_WIDTH];
    assign port_wdata[gi] = req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign pending     = req_read_i | req_write_i;
  assign any_pending = |pending;
  assign resp_onehot = NUM_PORTS'(1) << grant_q;

  // Search starts at rr_ptr in round-robin mode and at port 0 for fixed priority.
  always_comb begin
    int   start;
    int   cand;
    logic found;
    win_idx = '0;
    found   = 1'b0;
    start   = (ARB_MODE == 1) ? int'(rr_ptr_q) : 0;
    cand    = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = start + k;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      if (!found && pending[IDX_WIDTH'(cand)]) begin
        found   = 1'b1;
        win_idx = IDX_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    if (win_idx == IDX_WIDTH'(NUM_PORTS - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      req_resp_q  <= '0;
    end else begin
      req_resp_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (any_pending) begin
            // A simultaneous read and write is serviced as a write.
            mem_write_q <= req_write_i[win_idx];
            mem_read_q  <= ~req_write_i[win_idx];
            mem_addr_q  <= port_addr[win_idx];
            mem_be_q    <= port_be[win_idx];
            mem_wdata_q <= port_wdata[win_idx];
            grant_q     <= win_idx;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_resp_i) begin
            if (mem_read_q) begin
              rdata_q <= mem_rdata_i;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            req_resp_q  <= resp_onehot;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_resp_o        = req_resp_q;
  assign req_rdata_o       = rdata_q;
  assign grant_idx_o       = grant_q;
  assign mem_read_o        = mem_read_q;
  assign mem_write_o       = mem_write_q;
  assign mem_byte_enable_o = mem_be_q;
  assign mem_address_o     = mem_addr_q;
  assign mem_wdata_o       = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.                 |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     req_read = '0;
  logic [NP-1:0]     req_write = '0;
  logic [NP*BW-1:0]  req_be = '0;
  logic [NP*AW-1:0]  req_addr = '0;
  logic [NP*DW-1:0]  req_wdata = '0;
  logic [NP-1:0]     req_resp;
  logic [DW-1:0]     req_rdata;
  logic [1:0]        grant_idx;
  logic              mem_read;
  logic              mem_write;
  logic [BW-1:0]     mem_be;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_resp = 1'b0;
  logic [DW-1:0]     mem_rdata = '0;

  // Second instance: fixed priority with an always-ready memory.
  logic [NP-1:0]     f_read = '0;
  logic [NP-1:0]     f_write = '0;
  logic [NP*BW-1:0]  f_be = '0;
  logic [NP*AW-1:0]  f_addr = '0;
  logic [NP*DW-1:0]  f_wdata = '0;
  logic [NP-1:0]     f_resp;
  logic [DW-1:0]     f_rdata;
  logic [1:0]        f_grant;
  logic              f_mem_read;
  logic              f_mem_write;
  logic [BW-1:0]     f_mem_be;
  logic [AW-1:0]     f_mem_addr;
  logic [DW-1:0]     f_mem_wdata;
  logic              f_mem_resp;

  int checks = 0;
  int errors = 0;
  int lat_mode = 0;
  logic stray = 1'b0;

  typedef struct packed {
    logic [1:0]  port;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] rdata;
  } rsp_t;

  txn_t exp_q[$];
  rsp_t rsp_q[$];
  int   obs_port[$];
  int   obs_cyc[$];
  logic [31:0] refmem [logic [31:0]];
  logic [31:0] phys   [logic [31:0]];

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_read_i(req_read), .req_write_i(req_write), .req_byte_enable_i(req_be),
    .req_address_i(req_addr), .req_wdata_i(req_wdata),
    .req_resp_o(req_resp), .req_rdata_o(req_rdata), .grant_idx_o(grant_idx),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_byte_enable_o(mem_be),
    .mem_address_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_resp_i(mem_resp), .mem_rdata_i(mem_rdata)
  );

  assign f_mem_resp = f_mem_read | f_mem_write;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0)) u_fix (
    .clk(clk), .rst(rst),
    .req_read_i(f_read), .req_write_i(f_write), .req_byte_enable_i(f_be),
    .req_address_i(f_addr), .req_wdata_i(f_wdata),
    .req_resp_o(f_resp), .req_rdata_o(f_rdata), .grant_idx_o(f_grant),
    .mem_read_o(f_mem_read), .mem_write_o(f_mem_write), .mem_byte_enable_o(f_mem_be),
    .mem_address_o(f_mem_addr), .mem_wdata_o(f_mem_wdata),
    .mem_resp_i(f_mem_resp), .mem_rdata_i(32'h0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refmem.exists(a) ? refmem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : 32'h0;
  endfunction

  // Reference model: one transaction at a time; the arbiter is free again two
  // cycles after the cycle in which memory completes.
  initial begin : model
    int t, next_free, ptr, p;
    logic wait_resp;
    logic [31:0] last_rd;
    logic [NP-1:0] pend;
    txn_t x;
    rsp_t r;
    t = 0; next_free = 0; ptr = 0; wait_resp = 1'b0; last_rd = '0;
    forever begin
      @(posedge clk);
      t++;
      pend = req_read | req_write;
      if (rst) begin
        exp_q.delete();
        rsp_q.delete();
        ptr = 0; last_rd = '0; wait_resp = 1'b0; next_free = t + 1;
      end else if (wait_resp) begin
        if (mem_resp) begin
          wait_resp = 1'b0;
          next_free = t + 2;
        end
      end else if (t >= next_free && pend != '0) begin
        p = -1;
        for (int k = 0; k < NP; k++) if (p < 0 && pend[(ptr + k) % NP]) p = (ptr + k) % NP;
        x.port  = 2'(p);
        x.wr    = req_write[p];
        x.addr  = req_addr[p*AW +: AW];
        x.be    = req_be[p*BW +: BW];
        x.wdata = req_wdata[p*DW +: DW];
        if (x.wr) refmem[x.addr] = merge(ref_rd(x.addr), x.wdata, x.be);
        else      last_rd = ref_rd(x.addr);
        exp_q.push_back(x);
        r.port  = x.port;
        r.rdata = last_rd;
        rsp_q.push_back(r);
        ptr = (p + 1) % NP;
        wait_resp = 1'b1;
      end
    end
  end

  // Downstream memory with configurable latency (lat_mode < 0 means random 0..3).
  initial begin : responder
    int lat;
    lat = -1;
    forever begin
      @(negedge clk);
      #1;
      mem_resp = 1'b0;
      if (rst || !(mem_read || mem_write)) begin
        lat = -1;
      end else begin
        if (lat < 0) begin
          if (lat_mode < 0) lat = int'($urandom_range(0, 3));
          else              lat = lat_mode;
        end
        if (lat == 0) begin
          if (mem_write) begin
            phys[mem_addr] = merge(phys_rd(mem_addr), mem_wdata, mem_be);
            mem_rdata = $urandom;
          end else begin
            mem_rdata = phys_rd(mem_addr);
          end
          mem_resp = 1'b1;
          lat = -1;
        end else begin
          lat--;
        end
      end
      if (stray) mem_resp = 1'b1;
    end
  end

  initial begin : monitor
    logic prev;
    int   n;
    txn_t cur;
    rsp_t r;
    prev = 1'b0; n = 0; cur = '0;
    forever begin
      @(negedge clk);
      n++;
      if ((mem_read || mem_write) && !prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {62'd0, mem_read, mem_write}, 64'd0);
        end else begin
          cur = exp_q.pop_front();
          obs_port.push_back(int'(grant_idx));
          obs_cyc.push_back(n);
        end
      end
      if (mem_read || mem_write) begin
        chk("grant_idx", grant_idx, cur.port);
        chk("mem_write", mem_write, cur.wr);
        chk("mem_read", mem_read, !cur.wr);
        chk("mem_address", mem_addr, cur.addr);
        chk("mem_byte_enable", mem_be, cur.be);
        chk("mem_wdata", mem_wdata, cur.wdata);
      end
      if (req_resp != '0) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_resp", req_resp, 64'd0);
        end else begin
          r = rsp_q.pop_front();
          chk("req_resp", req_resp, NP'(1) << r.port);
          chk("req_rdata", req_rdata, r.rdata);
        end
      end
      prev = mem_read || mem_write;
    end
  end

  task automatic set_port(input int p, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
    req_read[p]          = rd;
    req_write[p]         = wr;
    req_addr[p*AW +: AW] = a;
    req_be[p*BW +: BW]   = be;
    req_wdata[p*DW +: DW] = wd;
  endtask

  task automatic do_op(input int p, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd,
                       input int chg_at, input logic [31:0] chg_addr);
    int n;
    logic done;
    @(negedge clk);
    set_port(p, rd, wr, a, be, wd);
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (req_resp[p]) begin
        done = 1'b1;
      end else if (n > 60) begin
        chk("op_timeout_resp", req_resp[p], 1);
        done = 1'b1;
      end else if (n == chg_at) begin
        req_addr[p*AW +: AW] = chg_addr;
      end
    end
    set_port(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic run_auto(input logic cont, input int per_port, input int budget);
    int   rem [NP];
    logic bsy [NP];
    int   n, op;
    logic all_done;
    for (int p = 0; p < NP; p++) begin rem[p] = per_port; bsy[p] = 1'b0; end
    n = 0; all_done = 1'b0;
    while (!all_done) begin
      @(negedge clk);
      n++;
      for (int p = 0; p < NP; p++) begin
        if (bsy[p] && req_resp[p]) begin
          bsy[p] = 1'b0;
          set_port(p, 1'b0, 1'b0, '0, '0, '0);
        end
        if (!bsy[p] && rem[p] > 0 && (cont || $urandom_range(0, 2) == 0)) begin
          op = int'($urandom_range(0, 2));
          set_port(p, op != 1, op != 0, 32'h100 + 32'($urandom_range(0, 7)) * 4,
                   4'($urandom), $urandom);
          bsy[p] = 1'b1;
          rem[p]--;
        end
      end
      all_done = 1'b1;
      for (int p = 0; p < NP; p++) if (bsy[p] || rem[p] > 0) all_done = 1'b0;
      if (!all_done && n > budget) begin
        chk("auto_phase_cycles", n, budget);
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, '0, '0, '0);
        all_done = 1'b1;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int exp_order [6];
    int ngr;
    logic got;
    exp_order = '{0, 1, 2, 3, 0, 1};
    refmem[32'h1000] = 32'hDEAD_BEEF; phys[32'h1000] = 32'hDEAD_BEEF;
    refmem[32'h40]   = 32'h1111_2222; phys[32'h40]   = 32'h1111_2222;
    refmem[32'h80]   = 32'h3333_4444; phys[32'h80]   = 32'h3333_4444;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_mem_be", mem_be, 0);
    chk("reset_mem_address", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_req_resp", req_resp, 0);
    chk("reset_req_rdata", req_rdata, 0);
    chk("reset_grant_idx", grant_idx, 0);

    lat_mode = 2;
    do_op(1, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, -1, '0);
    chk("single_read_rdata", req_rdata, 32'hDEAD_BEEF);
    chk("single_read_grant", grant_idx, 1);

    lat_mode = 0;
    do_op(0, 1'b0, 1'b1, 32'h20, 4'b1100, 32'hA5A5_0000, -1, '0);
    chk("write_keeps_rdata", req_rdata, 32'hDEAD_BEEF);
    chk("write_reached_memory", phys_rd(32'h20), 32'hA5A5_0000);

    lat_mode = 3;
    do_op(0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 2, 32'h80);
    chk("busy_change_rdata", req_rdata, 32'h1111_2222);

    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_resp_ignored", req_resp, 0);
    end

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    lat_mode = 0;
    obs_port.delete(); obs_cyc.delete();
    run_auto(1'b1, 2, 200);
    chk("rr_grant_count", obs_port.size(), 8);
    for (int i = 0; i < 6 && i < obs_port.size(); i++) chk("rr_order", obs_port[i], exp_order[i]);
    for (int i = 1; i < 6 && i < obs_cyc.size(); i++) chk("rr_spacing", obs_cyc[i] - obs_cyc[i-1], 3);

    lat_mode = 8;
    @(negedge clk);
    set_port(2, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    set_port(2, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_mem_read", mem_read, 0);
    chk("midreset_req_resp", req_resp, 0);
    chk("midreset_grant_idx", grant_idx, 0);
    chk("midreset_mem_address", mem_addr, 0);
    lat_mode = 0;
    obs_port.delete(); obs_cyc.delete();
    do_op(1, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, -1, '0);
    chk("post_reset_grant", (obs_port.size() == 1) ? obs_port[0] : 99, 1);
    chk("post_reset_rdata", req_rdata, 32'hDEAD_BEEF);

    lat_mode = -1;
    run_auto(1'b0, 30, 4000);

    f_read = 4'b0101;
    ngr = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (f_resp != '0) begin
        chk("fixed_winner", f_resp, 4'b0001);
        ngr++;
      end
    end
    chk("fixed_grant_count_ok", ngr >= 8, 1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (f_resp[0]) got = 1'b1;
    end
    f_read = 4'b0100;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (f_resp != '0) begin
        chk("fixed_port2_after_drop", f_resp, 4'b0100);
        got = 1'b1;
      end
    end
    chk("fixed_port2_served", got, 1);
    f_read = '0;

    repeat (5) @(negedge clk);
    chk("grant_queue_drained", exp_q.size(), 0);
    chk("resp_queue_drained", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
